// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: data width, ALU opcodes and
// sequencer states.
package alu_pkg;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    NEG_A      = 3'b000,
    INC_A      = 3'b001,
    ADD_ABC    = 3'b010,
    ADD_A_BSHR = 3'b011,
    AND_AB     = 3'b100,
    OR_AB      = 3'b101,
    CAT_LO     = 3'b110,
    NOP        = 3'b111
  } alu_opc_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } seq_state_e;
endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response channels between a host and the ALU command sequencer.
interface alu_cmd_sequencer_if #(parameter int NREGS = 4);
  localparam int AW = $clog2(NREGS);

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_load;
  logic [2:0]                cmd_opc;
  logic [AW-1:0]             cmd_dst;
  logic [AW-1:0]             cmd_srca;
  logic [AW-1:0]             cmd_srcb;
  logic                      cmd_cin;
  logic [alu_pkg::DATA_W-1:0] cmd_imm;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [alu_pkg::DATA_W-1:0] rsp_data;
  logic                      rsp_neg;
  logic                      rsp_zer;

  modport master (
    output cmd_valid, cmd_load, cmd_opc, cmd_dst, cmd_srca, cmd_srcb, cmd_cin, cmd_imm,
    output rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_neg, rsp_zer
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_opc, cmd_dst, cmd_srca, cmd_srcb, cmd_cin, cmd_imm,
    input  rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_neg, rsp_zer
  );
endinterface

// File: rtl/alu_cmd_regfile.sv
// NREGS x DATA_W operand file: two asynchronous read ports, one synchronous
// write port, cleared by reset.
module alu_cmd_regfile
  import alu_pkg::*;
#(
  parameter int NREGS = 4,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_a_i,
  input  logic [AW-1:0]     raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);
  logic [DATA_W-1:0] mem_q [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];
endmodule

// File: rtl/alu_cmd_sequencer.sv
// Accepts load/ALU commands, drives a combinational ALU from registers, samples
// its result after DRIVE_CYCLES and returns it over a valid/ready response.
//   state | meaning
//   IDLE  | ready for a command
//   DRIVE | ALU inputs held, waiting for settle count to expire
//   RESP  | response presented until accepted
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int NREGS        = 4,
  parameter int DRIVE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  alu_cmd_sequencer_if.slave  bus,
  output logic [2:0]          alu_opc_o,
  output logic [DATA_W-1:0]   alu_ina_o,
  output logic [DATA_W-1:0]   alu_inb_o,
  output logic                alu_inc_o,
  input  logic [DATA_W-1:0]   alu_outw_i,
  input  logic                alu_neg_i,
  input  logic                alu_zer_i
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = 4;

  seq_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        opc_q, opc_d;
  logic [DATA_W-1:0] ina_q, ina_d, inb_q, inb_d;
  logic              inc_q, inc_d;
  logic [AW-1:0]     dst_q, dst_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_neg_q, rsp_neg_d, rsp_zer_q, rsp_zer_d;
  logic              cmd_ready, rsp_valid;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DATA_W-1:0] rf_wdata, rd_a, rd_b;

  alu_cmd_regfile #(.NREGS(NREGS)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (bus.cmd_srca),
    .raddr_b_i (bus.cmd_srcb),
    .rdata_a_o (rd_a),
    .rdata_b_o (rd_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      opc_q      <= NOP;
      ina_q      <= '0;
      inb_q      <= '0;
      inc_q      <= 1'b0;
      dst_q      <= '0;
      rsp_data_q <= '0;
      rsp_neg_q  <= 1'b0;
      rsp_zer_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opc_q      <= opc_d;
      ina_q      <= ina_d;
      inb_q      <= inb_d;
      inc_q      <= inc_d;
      dst_q      <= dst_d;
      rsp_data_q <= rsp_data_d;
      rsp_neg_q  <= rsp_neg_d;
      rsp_zer_q  <= rsp_zer_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opc_d      = opc_q;
    ina_d      = ina_q;
    inb_d      = inb_q;
    inc_d      = inc_q;
    dst_d      = dst_q;
    rsp_data_d = rsp_data_q;
    rsp_neg_d  = rsp_neg_q;
    rsp_zer_d  = rsp_zer_q;
    rf_we      = 1'b0;
    rf_waddr   = dst_q;
    rf_wdata   = alu_outw_i;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          if (bus.cmd_load) begin
            rf_we      = 1'b1;
            rf_waddr   = bus.cmd_dst;
            rf_wdata   = bus.cmd_imm;
            rsp_data_d = bus.cmd_imm;
            rsp_neg_d  = bus.cmd_imm[DATA_W-1];
            rsp_zer_d  = (bus.cmd_imm == '0);
            state_d    = RESP;
          end else begin
            opc_d   = bus.cmd_opc;
            ina_d   = rd_a;
            inb_d   = rd_b;
            inc_d   = bus.cmd_cin;
            dst_d   = bus.cmd_dst;
            cnt_d   = CW'(DRIVE_CYCLES - 1);
            state_d = DRIVE;
          end
        end
      end
      DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // flags are taken from the ALU as-is, never recomputed here
          rf_we      = 1'b1;
          rsp_data_d = alu_outw_i;
          rsp_neg_d  = alu_neg_i;
          rsp_zer_d  = alu_zer_i;
          state_d    = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_neg   = rsp_neg_q;
  assign bus.rsp_zer   = rsp_zer_q;
  assign alu_opc_o     = opc_q;
  assign alu_ina_o     = ina_q;
  assign alu_inb_o     = inb_q;
  assign alu_inc_o     = inc_q;
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Command-driven initiator for the team's 16-bit combinational ALU (opcode/A/B/carry-in in; result/neg/zero out). It accepts instructions over a valid/ready command channel and reads operands from a small internal register file. It drives the ALU ports from registers, samples the result after a programmable settle time, writes it back, and returns result and flags on a valid/ready response channel. It sits between a host or test controller and one ALU instance.

Parameters:
NREGS, 4, number of 16-bit registers in the file (power of 2, 2..16)
DRIVE_CYCLES, 1, cycles ALU inputs are held before the result is sampled (1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_load  in  1  1 = write cmd_imm to dst with no ALU access
cmd_opc  in  3  ALU opcode
cmd_dst  in  log2(NREGS)  destination register
cmd_srca  in  log2(NREGS)  A operand register
cmd_srcb  in  log2(NREGS)  B operand register
cmd_cin  in  1  carry-in forwarded to ALU
cmd_imm  in  16  load immediate
alu_opc  out  3  to ALU opcode
alu_ina  out  16  to ALU A
alu_inb  out  16  to ALU B
alu_inc  out  1  to ALU carry-in
alu_outw  in  16  ALU result
alu_neg  in  1  ALU negative flag
alu_zer  in  1  ALU zero flag
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  16  written-back value
rsp_neg  out  1  negative flag of rsp_data
rsp_zer  out  1  zero flag of rsp_data

Behaviour:
- One clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values:
  - state = IDLE
  - cmd_ready = 1 after reset release
  - rsp_valid = 0; rsp_data = 0; rsp_neg = 0; rsp_zer = 0
  - alu_opc = 3'b111 (null op, ALU output 0); alu_ina = alu_inb = 0; alu_inc = 0
  - all registers = 0; settle counter = 0
- States: IDLE, DRIVE, RESP.
- IDLE:
  - cmd_ready = 1. A handshake occurs on cmd_valid & cmd_ready at a rising edge.
  - Load command: regfile[dst] <= cmd_imm. rsp_data <= cmd_imm, rsp_neg <= cmd_imm[15], rsp_zer <= (cmd_imm == 0). Next state RESP.
  - ALU command: alu_opc <= cmd_opc, alu_ina <= regfile[srca], alu_inb <= regfile[srcb], alu_inc <= cmd_cin, counter <= DRIVE_CYCLES-1. Next state DRIVE.
- DRIVE:
  - cmd_ready = 0. ALU port registers are held stable.
  - If counter != 0, decrement the counter.
  - If counter == 0, sample the ALU at this edge: regfile[dst] <= alu_outw, rsp_data <= alu_outw, rsp_neg <= alu_neg, rsp_zer <= alu_zer. Next state RESP.
- RESP:
  - rsp_valid = 1 and cmd_ready = 0. rsp_data and flags are held while rsp_ready = 0.
  - On rsp_ready, go to IDLE. rsp_valid falls the next cycle.
  - ALU port registers keep their last values (no toggling).
- Latency from command handshake to rsp_valid high: load = 1 cycle; ALU op = 1 + DRIVE_CYCLES cycles.
- Throughput: at most one command in flight. There are no bypass hazards because write-back completes before the next accept.
- Operand reads use register values at the accept edge. srca == srcb == dst is legal.
- Opcode 3'b111 is issued normally. It writes 0 to dst, with rsp_zer = 1 as reported by the ALU.
- Flags come from the ALU for ALU commands and are computed locally for loads. The sequencer never recomputes flags for ALU commands.
- Reset asserted in any state (including mid-DRIVE or while a response is pending):
  - immediate return to reset values; the in-flight command is discarded with no response
  - register file is cleared

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [2:0] for opcodes: NEG_A = 000, INC_A = 001, ADD_ABC = 010, ADD_A_BSHR = 011, AND_AB = 100, OR_AB = 101, CAT_LO = 110, NOP = 111
  - typedef enum for states IDLE/DRIVE/RESP
  - localparam DATA_W = 16
- One sub-module, alu_cmd_regfile: NREGS x 16, two asynchronous read ports, one synchronous write port, asynchronous clear on rst.

Test Plan:
- Loads: load R0 = 0x0005, then R1 = 0xFFF8 -> rsp_data 0x0005 (neg 0, zer 0), then 0xFFF8 (neg 1); each rsp_valid arrives 1 cycle after its handshake.
- Add with carry: ADD_ABC, A = R0, B = R1, cin = 1, dst = R2, DRIVE_CYCLES = 1 -> rsp_data 0xFFFE, neg 1, zer 0; rsp_valid 2 cycles after the handshake; R2 = 0xFFFE.
- Unary and shift ops: NEG_A on R0 -> 0xFFFB. ADD_A_BSHR, A = R0, B = R1 -> 0x0001. CAT_LO, A = R0, B = R1 -> 0x05F8. NOP -> 0x0000 with zer 1.
- Back-pressure: hold rsp_ready = 0 for 3 cycles with cmd_valid high -> rsp_data and flags stable, cmd_ready = 0 throughout; exactly one handshake on each channel after release.
- Settle time: DRIVE_CYCLES = 4 -> alu_* ports constant for 4 cycles; rsp_valid 5 cycles after the handshake.
- Reset mid-op: assert rst in the second DRIVE cycle (DRIVE_CYCLES = 4) -> rsp_valid never rises; alu_opc = 111 and all registers read 0 afterwards; cmd_ready = 1 one cycle after rst falls.
